exe_wr_handoff: RTL and testbench

Pipeline handoff buffer between the execute stage and the write stage. It captures the execute-stage result bundle when execute signals completion and presents it to the write stage with a valid/busy handshake. A two-entry skid structure lets execute retire one command while write is stalled. The block also exports the union of in-flight register/memory mutex bits for upstream hazard checking.

---
 rtl/exe_wr_handoff_if.sv | 60 ++++++
 rtl/exe_wr_handoff.sv | 134 +++++++++++++
 tb/tb_exe_wr_handoff.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/exe_wr_handoff_if.sv
// Execute-to-write handoff bus: execute-side bundle and backpressure,
// write-side head entry and handshake, plus hazard/occupancy status.
interface exe_wr_handoff_if #(
  parameter int MUTEX_W = 11
);
  logic               exe_reset;
  logic               exe_ready;
  logic               exe_waiting;
  logic [31:0]        exe_result;
  logic [31:0]        exe_result2;
  logic [31:0]        exe_result_push;
  logic [4:0]         exe_result_signals;
  logic [31:0]        exe_eip;
  logic [6:0]         exe_cmd;
  logic [3:0]         exe_cmdex;
  logic               exe_is_8bit;
  logic               exe_operand_32bit;
  logic [3:0]         exe_consumed;
  logic [MUTEX_W-1:0] exe_mutex_current;
  logic               exe_busy;

  logic               wr_busy;
  logic               wr_valid;
  logic [31:0]        wr_result;
  logic [31:0]        wr_result2;
  logic [31:0]        wr_result_push;
  logic [4:0]         wr_result_signals;
  logic [31:0]        wr_eip;
  logic [6:0]         wr_cmd;
  logic [3:0]         wr_cmdex;
  logic               wr_is_8bit;
  logic               wr_operand_32bit;
  logic [3:0]         wr_consumed;
  logic [MUTEX_W-1:0] wr_mutex;

  logic [MUTEX_W-1:0] mutex_pending;
  logic [1:0]         occupancy;

  // Environment side: drives the execute bundle and write backpressure.
  modport master (
    output exe_reset, exe_ready, exe_waiting, exe_result, exe_result2,
           exe_result_push, exe_result_signals, exe_eip, exe_cmd, exe_cmdex,
           exe_is_8bit, exe_operand_32bit, exe_consumed, exe_mutex_current,
           wr_busy,
    input  exe_busy, wr_valid, wr_result, wr_result2, wr_result_push,
           wr_result_signals, wr_eip, wr_cmd, wr_cmdex, wr_is_8bit,
           wr_operand_32bit, wr_consumed, wr_mutex, mutex_pending, occupancy
  );

  // Handoff buffer side.
  modport slave (
    input  exe_reset, exe_ready, exe_waiting, exe_result, exe_result2,
           exe_result_push, exe_result_signals, exe_eip, exe_cmd, exe_cmdex,
           exe_is_8bit, exe_operand_32bit, exe_consumed, exe_mutex_current,
           wr_busy,
    output exe_busy, wr_valid, wr_result, wr_result2, wr_result_push,
           wr_result_signals, wr_eip, wr_cmd, wr_cmdex, wr_is_8bit,
           wr_operand_32bit, wr_consumed, wr_mutex, mutex_pending, occupancy
  );
endinterface

// File: rtl/exe_wr_handoff.sv
// Execute -> write handoff buffer: main entry plus optional skid entry so
// execute can retire one more bundle while write is stalled.
module exe_wr_handoff #(
  parameter int MUTEX_W = 11,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  exe_wr_handoff_if.slave  bus
);

  typedef struct packed {
    logic [31:0]        result;
    logic [31:0]        result2;
    logic [31:0]        result_push;
    logic [4:0]         result_signals;
    logic [31:0]        eip;
    logic [6:0]         cmd;
    logic [3:0]         cmdex;
    logic               is_8bit;
    logic               operand_32bit;
    logic [3:0]         consumed;
    logic [MUTEX_W-1:0] mutex;
  } bundle_t;

  // Encoding equals the number of valid entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t  state_reg, state_next;
  bundle_t main_reg, main_next;
  bundle_t skid_reg, skid_next;
  bundle_t in_bundle;
  logic    exe_busy_reg, exe_busy_next;
  logic    accept, pop;
  logic    main_valid, skid_valid;

  assign in_bundle.result         = bus.exe_result;
  assign in_bundle.result2        = bus.exe_result2;
  assign in_bundle.result_push    = bus.exe_result_push;
  assign in_bundle.result_signals = bus.exe_result_signals;
  assign in_bundle.eip            = bus.exe_eip;
  assign in_bundle.cmd            = bus.exe_cmd;
  assign in_bundle.cmdex          = bus.exe_cmdex;
  assign in_bundle.is_8bit        = bus.exe_is_8bit;
  assign in_bundle.operand_32bit  = bus.exe_operand_32bit;
  assign in_bundle.consumed       = bus.exe_consumed;
  assign in_bundle.mutex          = bus.exe_mutex_current;

  assign main_valid = (state_reg != EMPTY);
  assign skid_valid = (state_reg == TWO);
  assign accept     = bus.exe_ready & ~bus.exe_waiting & ~exe_busy_reg;
  assign pop        = main_valid & ~bus.wr_busy;

  // State and entry registers; data is only zeroed by rst_n, a flush
  // merely invalidates entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      exe_busy_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      exe_busy_reg <= exe_busy_next;
    end
  end

  // Next-state and entry movement; flush overrides both accept and pop.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (bus.exe_reset) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_next  = in_bundle;
            state_next = ONE;
          end
        end
        ONE: begin
          if (pop && accept) begin
            main_next = in_bundle;
          end else if (pop) begin
            state_next = EMPTY;
          end else if (accept && (SKID_EN != 0)) begin
            skid_next  = in_bundle;
            state_next = TWO;
          end
        end
        TWO: begin
          // exe_busy is high here, so only a pop can move the state.
          if (pop) begin
            main_next  = skid_reg;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
    // Backpressure is asserted once no further bundle could be stored.
    exe_busy_next = (SKID_EN != 0) ? (state_next == TWO) : (state_next == ONE);
  end

  assign bus.exe_busy          = exe_busy_reg;
  assign bus.wr_valid          = main_valid;
  assign bus.wr_result         = main_reg.result;
  assign bus.wr_result2        = main_reg.result2;
  assign bus.wr_result_push    = main_reg.result_push;
  assign bus.wr_result_signals = main_reg.result_signals;
  assign bus.wr_eip            = main_reg.eip;
  assign bus.wr_cmd            = main_reg.cmd;
  assign bus.wr_cmdex          = main_reg.cmdex;
  assign bus.wr_is_8bit        = main_reg.is_8bit;
  assign bus.wr_operand_32bit  = main_reg.operand_32bit;
  assign bus.wr_consumed       = main_reg.consumed;
  assign bus.wr_mutex          = main_reg.mutex;
  assign bus.occupancy         = state_reg;

  // Hazard union: each bit is set if any valid entry holds it.
  for (genvar gi = 0; gi < MUTEX_W; gi++) begin : g_mutex
    assign bus.mutex_pending[gi] = (main_valid & main_reg.mutex[gi]) |
                                   (skid_valid & skid_reg.mutex[gi]);
  end

endmodule

// File: tb/tb_exe_wr_handoff.sv
// Scoreboard bench for exe_wr_handoff: stimulus pushes expected bundles,
// a negedge monitor pops and compares on every write handshake.
module tb_exe_wr_handoff;

  localparam int MW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exe_wr_handoff_if #(.MUTEX_W(MW)) bus ();

  exe_wr_handoff #(.MUTEX_W(MW), .SKID_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]   result;
    logic [31:0]   result2;
    logic [31:0]   eip;
    logic [6:0]    cmd;
    logic [MW-1:0] mutex;
  } exp_t;

  exp_t exp_q[$];
  int   vec_count = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_count++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a bundle; derived fields follow fixed formulas so expectations
  // can be written down by hand.
  task automatic drive(input logic [31:0] res, input logic [6:0] cmd,
                       input logic [MW-1:0] mtx, input bit expect_accept);
    exp_t e;
    bus.exe_ready         = 1'b1;
    bus.exe_result        = res;
    bus.exe_result2       = ~res;
    bus.exe_result_push   = res + 32'd1;
    bus.exe_eip           = res ^ 32'h0000_F0F0;
    bus.exe_cmd           = cmd;
    bus.exe_mutex_current = mtx;
    if (expect_accept) begin
      e.result  = res;
      e.result2 = ~res;
      e.eip     = res ^ 32'h0000_F0F0;
      e.cmd     = cmd;
      e.mutex   = mtx;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a handshake completes at the next edge when the head is valid,
  // write is not stalled and no flush/reset is in progress.
  always @(negedge clk) begin
    if (rst_n && !bus.exe_reset && bus.wr_valid && !bus.wr_busy) begin
      exp_t e;
      vec_count++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_pop: got unexpected result %h, expected none", bus.wr_result);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_result !== e.result || bus.wr_result2 !== e.result2 ||
            bus.wr_eip !== e.eip || bus.wr_cmd !== e.cmd || bus.wr_mutex !== e.mutex) begin
          miscompares++;
          $display("FAIL wr_pop: got res=%h res2=%h eip=%h cmd=%h mtx=%h expected res=%h res2=%h eip=%h cmd=%h mtx=%h",
                   bus.wr_result, bus.wr_result2, bus.wr_eip, bus.wr_cmd, bus.wr_mutex,
                   e.result, e.result2, e.eip, e.cmd, e.mutex);
        end else begin
          $display("wr pop: result=%h cmd=%h mutex=%h", bus.wr_result, bus.wr_cmd, bus.wr_mutex);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.exe_reset = 1'b0; bus.exe_ready = 1'b0; bus.exe_waiting = 1'b0;
    bus.exe_result = '0; bus.exe_result2 = '0; bus.exe_result_push = '0;
    bus.exe_result_signals = 5'h3; bus.exe_eip = '0; bus.exe_cmd = '0;
    bus.exe_cmdex = 4'h2; bus.exe_is_8bit = 1'b0; bus.exe_operand_32bit = 1'b1;
    bus.exe_consumed = 4'h3; bus.exe_mutex_current = '0; bus.wr_busy = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_exe_busy", 32'(bus.exe_busy), 32'd0);
    chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("rst_mutex_pending", 32'(bus.mutex_pending), 32'd0);
    chk("rst_wr_result", bus.wr_result, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single pass
    drive(32'h12345678, 7'h15, 11'h001, 1'b1);
    tick();
    bus.exe_ready = 1'b0;
    chk("single_wr_valid", 32'(bus.wr_valid), 32'd1);
    chk("single_wr_result", bus.wr_result, 32'h12345678);
    chk("single_wr_cmd", 32'(bus.wr_cmd), 32'h15);
    tick();
    chk("single_occ_after", 32'(bus.occupancy), 32'd0);

    // Stall fill, ignored third bundle, then drain; also the mutex union
    bus.wr_busy = 1'b1;
    drive(32'hA, 7'h01, 11'h004, 1'b1);
    tick();
    drive(32'hB, 7'h02, 11'h100, 1'b1);
    tick();
    chk("fill_occupancy", 32'(bus.occupancy), 32'd2);
    chk("fill_exe_busy", 32'(bus.exe_busy), 32'd1);
    chk("fill_wr_result", bus.wr_result, 32'hA);
    chk("fill_mutex_pending", 32'(bus.mutex_pending), 32'h104);
    drive(32'hC, 7'h03, 11'h010, 1'b0);
    tick();
    bus.exe_ready = 1'b0;
    chk("ignored_occupancy", 32'(bus.occupancy), 32'd2);
    chk("held_wr_result", bus.wr_result, 32'hA);
    chk("ignored_mutex_pending", 32'(bus.mutex_pending), 32'h104);
    bus.wr_busy = 1'b0;
    tick();
    chk("drain1_exe_busy", 32'(bus.exe_busy), 32'd0);
    chk("drain1_occupancy", 32'(bus.occupancy), 32'd1);
    chk("drain1_wr_result", bus.wr_result, 32'hB);
    chk("drain1_mutex_pending", 32'(bus.mutex_pending), 32'h100);
    tick();
    chk("drain2_occupancy", 32'(bus.occupancy), 32'd0);
    chk("drain2_mutex_pending", 32'(bus.mutex_pending), 32'h000);

    // Streaming: one bundle per cycle while write keeps up
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i), 7'(i + 16), 11'(1 << i), 1'b1);
      tick();
      chk("stream_occupancy", 32'(bus.occupancy), 32'd1);
      chk("stream_exe_busy", 32'(bus.exe_busy), 32'd0);
      chk("stream_wr_result", bus.wr_result, 32'(i));
    end
    bus.exe_ready = 1'b0;
    tick();
    chk("stream_occ_after", 32'(bus.occupancy), 32'd0);

    // Flush while full, with a bundle offered at the same time
    bus.wr_busy = 1'b1;
    drive(32'h21, 7'h21, 11'h002, 1'b1);
    tick();
    drive(32'h22, 7'h22, 11'h008, 1'b1);
    tick();
    chk("flush_pre_occupancy", 32'(bus.occupancy), 32'd2);
    drive(32'h23, 7'h23, 11'h020, 1'b0);
    bus.exe_reset = 1'b1;
    tick();
    bus.exe_reset = 1'b0;
    bus.exe_ready = 1'b0;
    exp_q.delete();
    chk("flush_occupancy", 32'(bus.occupancy), 32'd0);
    chk("flush_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("flush_exe_busy", 32'(bus.exe_busy), 32'd0);
    chk("flush_mutex_pending", 32'(bus.mutex_pending), 32'd0);

    // Flush from ONE: the offered bundle would otherwise fill the skid
    drive(32'h24, 7'h24, 11'h040, 1'b1);
    tick();
    drive(32'h25, 7'h25, 11'h080, 1'b0);
    bus.exe_reset = 1'b1;
    tick();
    bus.exe_reset = 1'b0;
    bus.exe_ready = 1'b0;
    exp_q.delete();
    chk("flush1_occupancy", 32'(bus.occupancy), 32'd0);
    chk("flush1_wr_valid", 32'(bus.wr_valid), 32'd0);
    bus.wr_busy = 1'b0;
    tick();
    chk("flush1_occ_later", 32'(bus.occupancy), 32'd0);

    // exe_waiting suppresses capture
    bus.exe_waiting = 1'b1;
    drive(32'h26, 7'h26, 11'h001, 1'b0);
    tick(); tick();
    chk("waiting_occupancy", 32'(bus.occupancy), 32'd0);
    chk("waiting_wr_valid", 32'(bus.wr_valid), 32'd0);
    bus.exe_waiting = 1'b0;
    bus.exe_ready = 1'b0;

    // rst_n while full
    bus.wr_busy = 1'b1;
    drive(32'h31, 7'h31, 11'h003, 1'b1);
    tick();
    drive(32'h32, 7'h32, 11'h00C, 1'b1);
    tick();
    bus.exe_ready = 1'b0;
    chk("rst2_pre_occupancy", 32'(bus.occupancy), 32'd2);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    chk("rst2_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst2_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("rst2_exe_busy", 32'(bus.exe_busy), 32'd0);
    chk("rst2_mutex_pending", 32'(bus.mutex_pending), 32'd0);
    chk("rst2_wr_result", bus.wr_result, 32'd0);
    rst_n = 1'b1;
    bus.wr_busy = 1'b0;

    // Post-reset sanity pass, then wait (bounded) for the scoreboard to drain
    drive(32'hCAFE_0001, 7'h7F, 11'h400, 1'b1);
    tick();
    bus.exe_ready = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
